sched_mac: RTL and testbench

Frame scheduler that time-multiplexes one shared biquad MAC datapath (coefficient mux, input mux, accumulator, rounding, state memory) across up to `N_CH` filter channels, e.g. the 200 Hz high-pass plus sibling bands of an equalizer. On each input-sample strobe it walks every enabled channel through the fixed two-phase Direct Form II sequence and drives the datapath control lines: term select, accumulator clear, state write, output capture and history shift. It replaces the per-filter `cntrl` instances so that all bands share one multiplier.

---
 rtl/sched_mac_pkg.sv | 27 ++
 rtl/sched_mac_busca_canal.sv | 26 ++
 rtl/sched_mac.sv | 169 ++++++++++++++++
 tb/tb_sched_mac.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/sched_mac_pkg.sv
// Shared definitions for the biquad MAC frame scheduler.
package sched_mac_pkg;

  typedef enum logic [3:0] {
    IDLE,
    CLR_A,
    MAC_A,
    WR_F,
    CLR_B,
    MAC_B,
    WR_Y,
    SHF,
    FIN
  } state_t;

  // Term selects: a-terms over (u, f1, f2), then b-terms over (f, f1, f2)
  localparam logic [3:0] SEL_U   = 4'd0;
  localparam logic [3:0] SEL_F1A = 4'd1;
  localparam logic [3:0] SEL_F2A = 4'd2;
  localparam logic [3:0] SEL_F   = 4'd3;
  localparam logic [3:0] SEL_F1B = 4'd4;
  localparam logic [3:0] SEL_F2B = 4'd5;

  localparam int N_TERMS    = 3;
  localparam int CYC_PER_CH = 11;

endpackage

// File: rtl/sched_mac_busca_canal.sv
// Finds the next enabled channel: lowest set bit of the mask, either from
// index 0 or strictly above the current index.
module busca_canal #(
  parameter int N_CH = 3,
  parameter int CH_W = 2
) (
  input  logic [N_CH-1:0] en_q,
  input  logic [CH_W-1:0] cur,
  input  logic            from_start,
  output logic [CH_W-1:0] nxt,
  output logic            vld
);

  // Scan downwards so the lowest qualifying index is the last one written
  always_comb begin
    nxt = '0;
    vld = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (en_q[i] && (from_start || (i > int'(cur)))) begin
        nxt = CH_W'(i);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sched_mac.sv
// Frame scheduler sharing one biquad MAC across N_CH channels.
//
// state | meaning
// IDLE  | waiting for a sample strobe (or a held pending one)
// CLR_A | clear accumulator before a-terms
// MAC_A | accumulate a-terms, sel = 0..2
// WR_F  | write rounded accumulator into state f
// CLR_B | clear accumulator before b-terms
// MAC_B | accumulate b-terms, sel = 3..5
// WR_Y  | capture rounded accumulator into output y
// SHF   | shift history f2<-f1, f1<-f
// FIN   | frame complete, done pulse; restarts if a strobe is pending
module sched_mac
  import sched_mac_pkg::*;
#(
  parameter int N_CH = 3,
  parameter int CH_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx,
  input  logic [N_CH-1:0] en,
  output logic [CH_W-1:0] ch,
  output logic [3:0]      sel,
  output logic            rst_acum,
  output logic            leer,
  output logic            leer_y,
  output logic            desp,
  output logic            busy,
  output logic            done,
  output logic            ovr
);

  state_t          state;
  logic [1:0]      t;
  logic [N_CH-1:0] en_q;
  logic            pending;

  logic            starting;
  logic [N_CH-1:0] scan_mask;
  logic [CH_W-1:0] nxt_ch;
  logic            nxt_vld;

  // A frame can only start from IDLE or FIN; there the live mask is the one
  // about to be latched, elsewhere the search walks the latched mask.
  assign starting  = (state == IDLE) || (state == FIN);
  assign scan_mask = starting ? en : en_q;
  assign busy      = (state != IDLE);

  busca_canal #(.N_CH(N_CH), .CH_W(CH_W)) u_busca (
    .en_q       (scan_mask),
    .cur        (ch),
    .from_start (starting),
    .nxt        (nxt_ch),
    .vld        (nxt_vld)
  );

  // Sequencer: state, term counter, pending/overrun and registered strobes
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      t        <= '0;
      en_q     <= '0;
      pending  <= 1'b0;
      ch       <= '0;
      sel      <= SEL_U;
      rst_acum <= 1'b0;
      leer     <= 1'b0;
      leer_y   <= 1'b0;
      desp     <= 1'b0;
      done     <= 1'b0;
      ovr      <= 1'b0;
    end else begin
      rst_acum <= 1'b0;
      leer     <= 1'b0;
      leer_y   <= 1'b0;
      desp     <= 1'b0;
      done     <= 1'b0;

      // Strobes arriving mid-frame are held once; a second one is lost
      if (rx && state != IDLE) begin
        if (pending) ovr <= 1'b1;
        else         pending <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (rx || pending) begin
            if (rx && pending) ovr <= 1'b1;
            pending <= 1'b0;
            en_q    <= en;
            if (nxt_vld) begin
              ch       <= nxt_ch;
              rst_acum <= 1'b1;
              state    <= CLR_A;
            end else begin
              done  <= 1'b1;
              state <= FIN;
            end
          end
        end
        CLR_A: begin
          t     <= '0;
          sel   <= SEL_U;
          state <= MAC_A;
        end
        MAC_A: begin
          if (t == 2'(N_TERMS - 1)) begin
            leer  <= 1'b1;
            state <= WR_F;
          end else begin
            t   <= t + 2'd1;
            sel <= SEL_U + 4'(t) + 4'd1;
          end
        end
        WR_F: begin
          rst_acum <= 1'b1;
          state    <= CLR_B;
        end
        CLR_B: begin
          t     <= '0;
          sel   <= SEL_F;
          state <= MAC_B;
        end
        MAC_B: begin
          if (t == 2'(N_TERMS - 1)) begin
            leer_y <= 1'b1;
            state  <= WR_Y;
          end else begin
            t   <= t + 2'd1;
            sel <= SEL_F + 4'(t) + 4'd1;
          end
        end
        WR_Y: begin
          desp  <= 1'b1;
          state <= SHF;
        end
        SHF: begin
          if (nxt_vld) begin
            ch       <= nxt_ch;
            rst_acum <= 1'b1;
            state    <= CLR_A;
          end else begin
            done  <= 1'b1;
            state <= FIN;
          end
        end
        FIN: begin
          if (pending) begin
            pending <= 1'b0;
            en_q    <= en;
            if (nxt_vld) begin
              ch       <= nxt_ch;
              rst_acum <= 1'b1;
              state    <= CLR_A;
            end else begin
              done  <= 1'b1;
              state <= FIN;
            end
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sched_mac.sv
// Scoreboard bench for sched_mac: a frame-level model queues the expected
// per-cycle control word, a negedge monitor pops and compares.
module tb_sched_mac;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b0;
  logic [2:0] en  = 3'b000;
  logic [1:0] d_ch;
  logic [3:0] d_sel;
  logic       d_rst_acum, d_leer, d_leer_y, d_desp, d_busy, d_done, d_ovr;

  sched_mac #(.N_CH(3), .CH_W(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .en       (en),
    .ch       (d_ch),
    .sel      (d_sel),
    .rst_acum (d_rst_acum),
    .leer     (d_leer),
    .leer_y   (d_leer_y),
    .desp     (d_desp),
    .busy     (d_busy),
    .done     (d_done),
    .ovr      (d_ovr)
  );

  always #5 clk = ~clk;

  // Expected per-busy-cycle word; stb = {done, desp, leer_y, leer, rst_acum}
  typedef struct {
    logic [1:0] ch;
    logic [3:0] sel;
    logic [4:0] stb;
  } ev_t;

  ev_t q[$];
  int  left     = 0;   // busy cycles remaining, counting the current one
  bit  pend     = 0;
  bit  m_ovr    = 0;
  int  ch_last  = 0;
  int  sel_last = 0;
  int  total    = 0;
  int  bad      = 0;
  bit  run_mon  = 0;
  bit  watch_ly1 = 0;
  bit  seen_ly1  = 0;

  task automatic push(input int c, input int s, input int k);
    ev_t e;
    e.ch  = 2'(c);
    e.sel = 4'(s);
    e.stb = 5'(k);
    q.push_back(e);
  endtask

  // One frame: 11 cycles per enabled channel in ascending order, then FIN
  task automatic start_frame(input logic [2:0] m);
    for (int c = 0; c < 3; c++) begin
      if (m[c]) begin
        push(c, sel_last, 1);
        push(c, 0, 0); push(c, 1, 0); push(c, 2, 0);
        push(c, 2, 2);
        push(c, 2, 1);
        push(c, 3, 0); push(c, 4, 0); push(c, 5, 0);
        push(c, 5, 4);
        push(c, 5, 8);
        ch_last  = c;
        sel_last = 5;
        left += 11;
      end
    end
    push(ch_last, sel_last, 16);
    left += 1;
  endtask

  task automatic model_step();
    bit p0;
    if (!rst) begin
      q.delete();
      left = 0; pend = 0; m_ovr = 0; ch_last = 0; sel_last = 0;
      return;
    end
    if (left > 0) begin
      p0 = pend;
      if (rx) begin
        if (pend) m_ovr = 1;
        else      pend = 1;
      end
      left--;
      if (left == 0 && p0) begin
        pend = 0;
        start_frame(en);
      end
    end else if (rx || pend) begin
      if (rx && pend) m_ovr = 1;
      pend = 0;
      start_frame(en);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic pulse();
    rx = 1'b1;
    cyc();
    rx = 1'b0;
  endtask

  // Monitor: every cycle compare busy/ovr and the control word
  always @(negedge clk) begin : mon
    ev_t e;
    logic [12:0] act, exp_w;
    if (run_mon) begin
      total++;
      if (watch_ly1 && d_leer_y && d_ch == 2'd1) seen_ly1 = 1;
      if (left > 0 && q.size() == 0) begin
        bad++;
        $display("FAIL cycle_word: queue empty while busy expected, dut busy=%0b", d_busy);
      end else begin
        if (left > 0) e = q.pop_front();
        else begin
          e.ch  = 2'(ch_last);
          e.sel = 4'(sel_last);
          e.stb = 5'd0;
        end
        act   = {d_busy, d_ovr, d_ch, d_sel,
                 d_done, d_desp, d_leer_y, d_leer, d_rst_acum};
        exp_w = {(left > 0), m_ovr, e.ch, e.sel, e.stb};
        if (act !== exp_w) begin
          bad++;
          $display("FAIL cycle_word at %0t: got busy=%0b ovr=%0b ch=%0d sel=%0d stb=%05b want busy=%0b ovr=%0b ch=%0d sel=%0d stb=%05b",
                   $time, act[12], act[11], act[10:9], act[8:5], act[4:0],
                   exp_w[12], exp_w[11], exp_w[10:9], exp_w[8:5], exp_w[4:0]);
        end
      end
    end
  end

  initial begin
    @(negedge clk);
    cyc();
    cyc();
    run_mon = 1;
    rst = 1'b1;
    cyc();

    // single channel
    en = 3'b001; pulse(); repeat (15) cyc();
    // channels 0 and 2, 1 skipped
    en = 3'b101; pulse(); repeat (26) cyc();
    // empty mask
    en = 3'b000; pulse(); repeat (4) cyc();
    // pending restart then overrun
    en = 3'b111; pulse(); repeat (9) cyc();
    pulse(); repeat (9) cyc();
    pulse(); repeat (70) cyc();
    rst = 1'b0; cyc(); rst = 1'b1; cyc();
    // reset mid-frame aborts channel 1
    en = 3'b011; watch_ly1 = 1; seen_ly1 = 0;
    pulse(); repeat (14) cyc();
    rst = 1'b0; cyc(); rst = 1'b1;
    repeat (30) cyc();
    watch_ly1 = 0;
    total++;
    if (seen_ly1) begin
      bad++;
      $display("FAIL abort_no_ch1: got leer_y on ch1=1 want 0");
    end
    // mask latched at rx
    en = 3'b111; pulse(); repeat (4) cyc();
    en = 3'b001; repeat (40) cyc();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      en  = 3'($urandom);
      rx  = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 499) != 0);
      cyc();
    end
    rx = 1'b0; rst = 1'b1;
    repeat (80) cyc();

    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d queued words left want 0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
